// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: drives the instruction-memory request, owns the PC and
// the IF/ID register, with a one-entry skid buffer for decode back-pressure.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          OPC_MSB  = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [4:0]  if_id_opcode,
  output logic [31:0] if_id_pc_plus4
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pend_pc, pend_pc_nxt;
  logic        skid_vld, skid_vld_nxt;
  logic [31:0] skid_pc, skid_pc_nxt;
  logic [31:0] skid_instr, skid_instr_nxt;
  logic        vld_p1, vld_p1_nxt;
  logic [31:0] pc_p1, pc_p1_nxt;
  logic [31:0] instr_p1, instr_p1_nxt;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = pc;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    pend_pc_nxt    = pend_pc;
    skid_vld_nxt   = skid_vld;
    skid_pc_nxt    = skid_pc;
    skid_instr_nxt = skid_instr;
    vld_p1_nxt     = vld_p1;
    pc_p1_nxt      = pc_p1;
    instr_p1_nxt   = instr_p1;

    if (redirect_valid && (!imem_req || imem_ready)) begin
      // Nothing in flight (or it returns now and is dropped): restart at once.
      pc_nxt       = word_align(redirect_pc);
      vld_p1_nxt   = 1'b0;
      skid_vld_nxt = 1'b0;
      state_nxt    = FETCH;
    end else if (redirect_valid) begin
      // A request is outstanding; its address must stay put until it completes.
      pend_pc_nxt  = word_align(redirect_pc);
      vld_p1_nxt   = 1'b0;
      skid_vld_nxt = 1'b0;
      state_nxt    = DRAIN;
    end else begin
      unique case (state)
        BOOT: state_nxt = FETCH;
        FETCH: begin
          if (imem_ready) begin
            pc_nxt = pc + 32'd4;
            if (vld_p1 && stall) begin
              skid_vld_nxt   = 1'b1;
              skid_pc_nxt    = pc;
              skid_instr_nxt = imem_rdata;
              state_nxt      = HOLD;
            end else begin
              vld_p1_nxt   = 1'b1;
              pc_p1_nxt    = pc;
              instr_p1_nxt = imem_rdata;
            end
          end else if (!stall) begin
            vld_p1_nxt = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            vld_p1_nxt   = skid_vld;
            pc_p1_nxt    = skid_pc;
            instr_p1_nxt = skid_instr;
            skid_vld_nxt = 1'b0;
            state_nxt    = FETCH;
          end
        end
        DRAIN: begin
          if (imem_ready) begin
            pc_nxt    = pend_pc;
            state_nxt = FETCH;
          end
        end
        default: state_nxt = BOOT;
      endcase
    end
  end

  // ---- IF/ID register boundary ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      pend_pc  <= 32'h0;
      skid_vld <= 1'b0;
      vld_p1   <= 1'b0;
      pc_p1    <= 32'h0;
      instr_p1 <= 32'h0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      pend_pc  <= pend_pc_nxt;
      skid_vld <= skid_vld_nxt;
      vld_p1   <= vld_p1_nxt;
      pc_p1    <= pc_p1_nxt;
      instr_p1 <= instr_p1_nxt;
    end
  end

  always_ff @(posedge clk) begin
    skid_pc    <= skid_pc_nxt;
    skid_instr <= skid_instr_nxt;
  end

  assign if_id_valid    = vld_p1;
  assign if_id_pc       = pc_p1;
  assign if_id_instr    = instr_p1;
  assign if_id_opcode   = instr_p1[OPC_MSB -: 5];
  assign if_id_pc_plus4 = pc_p1 + 32'd4;

endmodule
